sfx_scheduler: RTL
==================

# sfx_scheduler

Sound-effect scheduler for the FPGA audio path. It arbitrates game-event sound requests and walks the granted effect's note range in the shared note ROM. It drives a square-wave tone and hands samples to the audio controller's output FIFO. It sits between game logic and the audio controller, and it is the only master of the note ROM address port.

## Interface
- NUM_SFX, 4, number of requesters/effects; index NUM_SFX-1 has highest priority
- ADDR_W, 14, note ROM address width
- DELAY_W, 19, note ROM data width (tone half-period in clocks; 0 = rest)
- BEAT_TICKS, 2500000, clocks per note (≥4)
- AMPLITUDE, 100000000, square-wave magnitude (32-bit signed)

- CLOCK_50  in  1  system clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- req  in  NUM_SFX  one-cycle request pulses, one bit per effect
- loop_en  in  NUM_SFX  per-effect loop enable (see Configuration)
- rom_addr  out  ADDR_W  note ROM address (registered ROM, 1-cycle read latency)
- rom_q  in  DELAY_W  note ROM data
- audio_out_allowed  in  1  audio controller FIFO has room
- write_audio_out  out  1  sample write strobe
- sample  out  32  signed sample, same to both channels
- busy  out  1  effect playing
- active_id  out  $clog2(NUM_SFX)  index of playing effect
- done  out  1  one-cycle pulse when a non-looping effect finishes

## Operation
- Effect i occupies the ROM range SFX_START[i]..SFX_END[i], inclusive. The range is given by package constants.
- pending[NUM_SFX-1:0] is set by req and cleared when that effect is granted. A req on a pending bit is idempotent.
- States: IDLE, FETCH, PLAY.
- IDLE: if any pending bit is set, grant the highest index, set rom_addr=SFX_START[id], and go to FETCH.
- FETCH: lasts exactly 1 cycle, then PLAY.
- PLAY: on its first cycle it captures rom_q into the note register. The tone counter restarts at 0 and snd=0.
- Beat counter: runs 0..BEAT_TICKS-1 across FETCH+PLAY, so each note lasts exactly BEAT_TICKS clocks.
- At the terminal beat count, take the first of these that applies:
  - A higher-priority effect is pending: preempt, grant it, FETCH its start.
  - rom_addr≠SFX_END[id]: rom_addr+1, FETCH.
  - End reached and looping: rom_addr=SFX_START[id], FETCH.
  - End reached and not looping: pulse done. Then grant the highest pending effect (FETCH), or go to IDLE if none is pending.
- A preempted effect is dropped. It is not resumed.
- A req for the currently playing id while in PLAY/FETCH sets pending. That effect restarts after the current one ends.
- Tone: the half-period counter counts 0..note. On reaching note it resets and toggles snd. If note=0, snd is held at 0.
- sample = +AMPLITUDE if snd, −AMPLITUDE otherwise. sample = 0 if note=0, in IDLE, or in FETCH.
- write_audio_out = audio_out_allowed & busy. It is registered, so it follows audio_out_allowed by 1 cycle.
- busy = 1 in FETCH/PLAY. active_id holds the last grant.

## Timing
- Reset (any state, mid-note included): state IDLE, pending=0, rom_addr=0, sample=0, write_audio_out=0, busy=0, active_id=0, done=0, counters 0.
- req at edge N → pending at N+1 → FETCH at N+2 (from IDLE) → first nonzero sample no earlier than N+3.
- Simultaneous req bits: all are latched, and the highest index is granted first.
- A req arriving on the same cycle as a terminal beat is latched. It is not considered for that decision.
- done is asserted for exactly 1 cycle, on the cycle that leaves PLAY.
- Arithmetic is unsigned. Counters are sized with $clog2, and wrap is never reached.

## Configuration
- SFX_LOOP_EN defined: loop_en[i] selects looping for effect i.
- SFX_LOOP_EN undefined: loop_en is ignored and every effect is one-shot. The loop compare logic is not synthesized.

## Structure
- Package sfx_pkg holds:
  - the state enum (IDLE/FETCH/PLAY)
  - SFX_START/SFX_END constant arrays
  - effect id constants (SFX_MARIO=0, SFX_HIT=1, SFX_MISS=2, SFX_WIN=3)
- Sub-module sfx_tone_gen contains the half-period counter, snd, and sample selection. Its inputs are note, restart, and enable.

## Test plan
Run all scenarios with BEAT_TICKS=8, a ROM model with range 0: 0..2 and range 3: 10..11, and a delay of 3 at every address unless noted.
- req[0] once → rom_addr 0,1,2 with 8 clocks each. sample toggles ±AMPLITUDE every 4 clocks. done pulses once. Then IDLE with sample=0.
- req[0] and req[3] in the same cycle → effect 3 plays addr 10,11, then effect 0 plays addr 0..2. done pulses twice.
- req[3] during effect 0's second note → at that note's terminal count, effect 3 starts at addr 10. Effect 0 is not resumed.
- rom_q=0 at addr 1 → sample=0 for that entire note, and snd resumes toggling at addr 2.
- With SFX_LOOP_EN and loop_en[0]=1 → addr sequence 0,1,2,0,1,… with no done pulse. A resetn low pulse mid-note → IDLE next cycle with all outputs at their reset values.
- audio_out_allowed toggling during playback → write_audio_out mirrors it 1 cycle later. write_audio_out stays 0 in IDLE.

Source files
------------

// File: rtl/sfx_pkg.sv
// Shared types and note-ROM layout for the sound-effect scheduler.
// Effect ids double as arbitration priority: a higher id wins.
package sfx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2
  } sfx_state_t;

  localparam int SFX_COUNT = 4;

  localparam int SFX_MARIO = 0;
  localparam int SFX_HIT   = 1;
  localparam int SFX_MISS  = 2;
  localparam int SFX_WIN   = 3;

  // Inclusive note ranges in the shared note ROM, indexed by effect id.
  localparam int unsigned SFX_START [SFX_COUNT] = '{0, 4, 6, 10};
  localparam int unsigned SFX_END   [SFX_COUNT] = '{2, 5, 8, 11};

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave tone generator: toggles snd every note+1 clocks and maps it
// to a signed sample; a zero note is a rest.
module sfx_tone_gen #(
  parameter int                 DELAY_W   = 19,
  parameter logic signed [31:0] AMPLITUDE = 32'sd100000000
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic [DELAY_W-1:0] note,
  input  logic               restart,
  input  logic               enable,
  output logic signed [31:0] sample
);

  logic [DELAY_W-1:0] half_cnt;
  logic               snd;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples values from before the edge.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      half_cnt <= '0;
      snd      <= 1'b0;
    end else if (restart) begin
      half_cnt <= '0;
      snd      <= 1'b0;
    end else if (enable) begin
      if (note == '0) begin
        half_cnt <= '0;
        snd      <= 1'b0;
      end else if (half_cnt == note) begin
        half_cnt <= '0;
        snd      <= ~snd;
      end else begin
        half_cnt <= half_cnt + DELAY_W'(1);
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first, which
  // rules out inferred latches on any path.
  always_comb begin
    sample = 32'sd0;
    if (enable && (note != '0)) begin
      sample = snd ? AMPLITUDE : -AMPLITUDE;
    end
  end

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: arbitrates effect requests, walks the note ROM and
// drives the tone generator. Define SFX_LOOP_EN to honour per-effect loop_en.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int                 NUM_SFX    = 4,
  parameter int                 ADDR_W     = 14,
  parameter int                 DELAY_W    = 19,
  parameter int                 BEAT_TICKS = 2500000,
  parameter logic signed [31:0] AMPLITUDE  = 32'sd100000000,
  localparam int                ID_W       = $clog2(NUM_SFX)
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [NUM_SFX-1:0]  req,
  input  logic [NUM_SFX-1:0]  loop_en,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DELAY_W-1:0]  rom_q,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic signed [31:0]  sample,
  output logic                busy,
  output logic [ID_W-1:0]     active_id,
  output logic                done
);

  localparam int BEAT_W = $clog2(BEAT_TICKS);

  sfx_state_t         state;
  logic [NUM_SFX-1:0] pending;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [DELAY_W-1:0] note;

  logic [ID_W-1:0]    pick_id;
  logic [NUM_SFX-1:0] grant_mask;
  logic [NUM_SFX-1:0] higher_mask;
  logic [ADDR_W-1:0]  start_addr;
  logic [ADDR_W-1:0]  loop_addr;
  logic [ADDR_W-1:0]  end_addr;
  logic               any_pending;
  logic               higher_pending;
  logic               at_end;
  logic               loop_sel;
  logic               terminal;
  logic               play_first;
  logic               finish;
  logic               grant;
  logic               busy_nxt;
  logic               tone_en;

`ifdef SFX_LOOP_EN
  assign loop_sel = loop_en[active_id];
`else
  logic unused_loop_en;
  assign unused_loop_en = ^loop_en;
  assign loop_sel       = 1'b0;
`endif

  // Arbitration and end-of-beat decisions; pending is the registered copy,
  // so a req arriving on a terminal beat only counts from the next decision.
  always_comb begin
    pick_id     = '0;
    higher_mask = '0;
    grant_mask  = '0;
    for (int i = 0; i < NUM_SFX; i++) begin
      if (pending[i]) pick_id = ID_W'(i);
      higher_mask[i] = (i > int'(active_id));
    end

    any_pending    = |pending;
    higher_pending = |(pending & higher_mask);
    start_addr     = ADDR_W'(SFX_START[pick_id]);
    loop_addr      = ADDR_W'(SFX_START[active_id]);
    end_addr       = ADDR_W'(SFX_END[active_id]);
    at_end         = (rom_addr == end_addr);

    terminal   = (state == PLAY) && (beat_cnt == BEAT_W'(BEAT_TICKS - 1));
    play_first = (state == PLAY) && (beat_cnt == BEAT_W'(1));
    finish     = terminal && !higher_pending && at_end && !loop_sel;
    grant      = ((state == IDLE) && any_pending)
              || (terminal && higher_pending)
              || (finish && any_pending);
    busy_nxt   = grant || ((state != IDLE) && !finish);
    tone_en    = (state == PLAY) && !play_first;

    if (grant) grant_mask[pick_id] = 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state           <= IDLE;
      pending         <= '0;
      rom_addr        <= '0;
      active_id       <= '0;
      beat_cnt        <= '0;
      note            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      write_audio_out <= 1'b0;
    end else begin
      pending         <= (pending & ~grant_mask) | req;
      busy            <= busy_nxt;
      write_audio_out <= audio_out_allowed & busy_nxt;
      done            <= finish;

      // The ROM answers one cycle after the FETCH address, i.e. in PLAY's first cycle.
      if (play_first) note <= rom_q;

      if (grant) begin
        state     <= FETCH;
        active_id <= pick_id;
        rom_addr  <= start_addr;
        beat_cnt  <= '0;
      end else begin
        case (state)
          IDLE: beat_cnt <= '0;
          FETCH: begin
            state    <= PLAY;
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
          PLAY: begin
            if (terminal) begin
              beat_cnt <= '0;
              if (!at_end) begin
                rom_addr <= rom_addr + ADDR_W'(1);
                state    <= FETCH;
              end else if (loop_sel) begin
                rom_addr <= loop_addr;
                state    <= FETCH;
              end else begin
                state <= IDLE;
              end
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  sfx_tone_gen #(
    .DELAY_W   (DELAY_W),
    .AMPLITUDE (AMPLITUDE)
  ) u_tone (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .note     (note),
    .restart  (play_first),
    .enable   (tone_en),
    .sample   (sample)
  );

endmodule
